// File: rtl/hypercorex_inst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hypercorex_inst_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//                - fetch_state_e : sequencer state encoding (IDLE/RUN/DONE)
//                - InstNop       : all-zero word driven to the decoder when no
//                                  instruction is valid
//  Revision    : 1.0 - initial release
// ============================================================================
package hypercorex_inst_pkg;

  // Sequencer states, explicitly encoded on two bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Widest instruction word the NOP constant covers; users slice it down.
  localparam int unsigned MaxInstWidth = 64;

  // Decoder treats an all-zero word as a no-operation.
  localparam logic [MaxInstWidth-1:0] InstNop = '0;

endpackage : hypercorex_inst_pkg
`default_nettype wire

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_mem
//  Description : Flop-based program memory. One synchronous write port and
//                one combinational read port. Contents are not reset.
//  Ports       : clk        - clock
//                i_wr_en    - write strobe
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_addr  - read address
//                o_rd_data  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_mem
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(INST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [INST_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [INST_WIDTH-1:0] o_rd_data
);

  logic [INST_WIDTH-1:0] r_mem [INST_DEPTH];

  // No reset on the array: program contents survive a reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : inst_fetch_mem
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_ctrl
//  Description : Instruction fetch / sequencer stage. Holds the program
//                memory, runs the PC with a single hardware loop region and
//                presents one instruction per cycle to the decoder.
//                Optional single-step mode is built when INST_FETCH_STEP_EN
//                is defined (adds step_mode_i / step_i).
//  Ports       : clk_i, rst_i        - clock, async active-high reset
//                prog_wr_*_i         - program memory write port (IDLE only)
//                cfg_*_i             - program end / loop config, latched on
//                                      start
//                start_i, stop_i     - run control pulses
//                stall_i             - downstream back-pressure
//                step_mode_i, step_i - single-step control (optional)
//                inst_code_o         - instruction to decoder (NOP if invalid)
//                inst_valid_o        - inst_code_o is live
//                pc_o                - current PC
//                busy_o              - sequencer is running
//                done_o              - one-cycle pulse on normal completion
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned INST_DEPTH     = 64,
  parameter int unsigned LOOP_CNT_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH     = $clog2(INST_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      prog_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]     prog_wr_addr_i,
  input  logic [INST_WIDTH-1:0]     prog_wr_data_i,
  input  logic [ADDR_WIDTH-1:0]     cfg_prog_end_i,
  input  logic [ADDR_WIDTH-1:0]     cfg_loop_start_i,
  input  logic [ADDR_WIDTH-1:0]     cfg_loop_end_i,
  input  logic [LOOP_CNT_WIDTH-1:0] cfg_loop_count_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      stall_i,
`ifdef INST_FETCH_STEP_EN
  input  logic                      step_mode_i,
  input  logic                      step_i,
`endif
  output logic [INST_WIDTH-1:0]     inst_code_o,
  output logic                      inst_valid_o,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic                      busy_o,
  output logic                      done_o
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  fetch_state_e              r_state;
  fetch_state_e              w_state_next;

  logic [ADDR_WIDTH-1:0]     r_pc;
  logic [ADDR_WIDTH-1:0]     w_pc_next;
  logic [LOOP_CNT_WIDTH-1:0] r_iter;
  logic [LOOP_CNT_WIDTH-1:0] w_iter_next;

  logic [ADDR_WIDTH-1:0]     r_prog_end;
  logic [ADDR_WIDTH-1:0]     r_loop_start;
  logic [ADDR_WIDTH-1:0]     r_loop_end;
  logic [LOOP_CNT_WIDTH-1:0] r_loop_count;

  logic                      w_start_ok;
  logic                      w_step_ok;
  logic                      w_valid;
  logic                      w_consume;
  logic                      w_loop_ok;
  logic                      w_loop_back;
  logic [LOOP_CNT_WIDTH:0]   w_iter_inc;
  logic                      w_mem_we;
  logic [INST_WIDTH-1:0]     w_mem_rd;

  // --------------------------------------------------------------------------
  // Program memory
  // --------------------------------------------------------------------------
  // Writes are only honoured while idle so a running program is never
  // modified underneath the PC.
  assign w_mem_we = prog_wr_en_i && (r_state == IDLE);

  inst_fetch_mem #(
    .INST_WIDTH (INST_WIDTH),
    .INST_DEPTH (INST_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_inst_fetch_mem (
    .clk       (clk_i),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (prog_wr_addr_i),
    .i_wr_data (prog_wr_data_i),
    .i_rd_addr (r_pc),
    .o_rd_data (w_mem_rd)
  );

  // --------------------------------------------------------------------------
  // Step gating
  // --------------------------------------------------------------------------
`ifdef INST_FETCH_STEP_EN
  // In step mode an instruction is only offered in the cycle of a step pulse.
  assign w_step_ok = !step_mode_i || step_i;
`else
  assign w_step_ok = 1'b1;
`endif

  // Stop has priority over a simultaneous start.
  assign w_start_ok = start_i && !stop_i;

  assign w_valid   = (r_state == RUN) && w_step_ok;
  assign w_consume = w_valid && !stall_i;

  // --------------------------------------------------------------------------
  // Loop decision
  // --------------------------------------------------------------------------
  // A loop region that is inverted or extends past the program end is treated
  // as absent. The extra counter bit keeps iter+1 from wrapping at the
  // maximum loop count.
  assign w_loop_ok   = (r_loop_end >= r_loop_start) && (r_loop_end <= r_prog_end);
  assign w_iter_inc  = {1'b0, r_iter} + (LOOP_CNT_WIDTH+1)'(1);
  assign w_loop_back = w_loop_ok && (r_pc == r_loop_end) &&
                       (w_iter_inc < {1'b0, r_loop_count});

  // --------------------------------------------------------------------------
  // FSM: state register (also carries PC, iteration counter and config)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_iter       <= '0;
      r_prog_end   <= '0;
      r_loop_start <= '0;
      r_loop_end   <= '0;
      r_loop_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_iter  <= w_iter_next;
      if ((r_state == IDLE) && w_start_ok) begin
        r_prog_end   <= cfg_prog_end_i;
        r_loop_start <= cfg_loop_start_i;
        r_loop_end   <= cfg_loop_end_i;
        r_loop_count <= cfg_loop_count_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_iter_next  = r_iter;

    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_next = RUN;
          w_pc_next    = '0;
          w_iter_next  = '0;
        end
      end

      RUN: begin
        if (stop_i) begin
          // Abort: the PC is discarded regardless of any consume this cycle.
          w_state_next = IDLE;
          w_pc_next    = '0;
          w_iter_next  = '0;
        end else if (w_consume) begin
          if (w_loop_back) begin
            // Loop-back beats program end when both sit on the same address.
            w_pc_next   = r_loop_start;
            w_iter_next = w_iter_inc[LOOP_CNT_WIDTH-1:0];
          end else if (r_pc == r_prog_end) begin
            w_state_next = DONE;
            w_iter_next  = '0;
          end else begin
            w_pc_next = r_pc + ADDR_WIDTH'(1);
            if (r_pc == r_loop_end) begin
              w_iter_next = '0;
            end
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    inst_valid_o = w_valid;
    busy_o       = (r_state == RUN);
    done_o       = (r_state == DONE);
    inst_code_o  = w_valid ? w_mem_rd : InstNop[INST_WIDTH-1:0];
  end

  assign pc_o = r_pc;

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction fetch/sequencer stage feeding the instruction decoder. Holds a small flop-based program memory, runs a program counter (PC) with one hardware loop region, and presents one instruction per cycle on inst_code_o. Stalls when the datapath cannot accept an instruction, for example when the item memory is not ready. Host loads the program and loop config while idle, then pulses start.

Parameters:
InstWidth, 32, instruction word width (matches decoder)
InstDepth, 64, program memory entries
LoopCntWidth, 16, width of loop iteration count
AddrWidth, $clog2(InstDepth), derived PC/address width (don't touch)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
prog_wr_en_i  in  1  program memory write strobe
prog_wr_addr_i  in  AddrWidth  write address
prog_wr_data_i  in  InstWidth  instruction word to write
cfg_prog_end_i  in  AddrWidth  address of last instruction
cfg_loop_start_i  in  AddrWidth  first address of loop body
cfg_loop_end_i  in  AddrWidth  last address of loop body
cfg_loop_count_i  in  LoopCntWidth  total loop body executions
start_i  in  1  start pulse
stop_i  in  1  abort pulse
stall_i  in  1  downstream cannot consume the current instruction
inst_code_o  out  InstWidth  current instruction to decoder
inst_valid_o  out  1  inst_code_o is live
pc_o  out  AddrWidth  current PC
busy_o  out  1  state is RUN
done_o  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE, PC=0, iteration counter=0, latched cfg=0, inst_valid_o=0, busy_o=0, done_o=0. Program memory contents are not reset.
- inst_code_o = mem[PC] combinationally. It is forced to 0 when inst_valid_o=0, so the decoder sees a NOP.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - prog_wr_en_i writes mem[prog_wr_addr_i] on the clock edge.
  - start_i latches all cfg_* values, sets PC=0 and iter=0, and moves to RUN.
- RUN:
  - inst_valid_o=1 and busy_o=1.
  - An instruction is consumed on a cycle with inst_valid_o && !stall_i. The PC updates only on consume.
  - Priority of the next PC on consume:
    (a) PC==loop_end and iter+1 < loop_count: PC=loop_start, iter+=1.
    (b) PC==prog_end: go to DONE; PC holds.
    (c) otherwise PC+1.
  - When (a) and prog_end coincide at the same address, (a) wins.
  - At the loop-exit consume, iter is cleared to 0.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Loop count 0 or 1: the loop body executes once (no repeat). loop_end < loop_start, or loop_end > prog_end: loop is never taken; the program runs linearly.
- stop_i in RUN: next cycle is IDLE, PC=0, no done_o. The instruction presented in the stop cycle counts as consumed only if !stall_i; the PC is still discarded.
- start_i and stop_i in the same cycle: stop wins; the block stays in IDLE.
- start_i while in RUN or DONE: ignored.
- prog_wr_en_i outside IDLE: ignored (no write).
- PC at InstDepth-1 with prog_end=InstDepth-1: completes; no wrap-around.
- stall_i held indefinitely: PC and inst_code_o stay stable.
- Reset asserted mid-RUN: immediate return to reset values.

Optional Feature:
Macro INST_FETCH_STEP_EN.
- Defined: adds ports step_mode_i (1) and step_i (1). With step_mode_i=1 in RUN, inst_valid_o is asserted only in the cycle step_i=1. Each step pulse consumes at most one instruction, subject to stall_i. With step_mode_i=0, behaviour is as normal.
- Not defined: the ports are absent and the block behaves as with step_mode_i=0.

Decomposition:
- hypercorex_inst_pkg gets:
  - fetch_state_e typedef (IDLE/RUN/DONE)
  - InstNop constant (all zero), used for inst_code_o when invalid.
- One sub-module: inst_fetch_mem. It is the flop array with one synchronous write port and one combinational read port, parameterised by InstWidth/InstDepth.
- The FSM, PC and loop counter stay in the top module.

Test Plan:
- Load 4 words A,B,C,D at 0..3, prog_end=3, loop disabled, no stall, start → inst_code_o A,B,C,D on 4 consecutive cycles; done_o pulses the following cycle; inst_valid_o=0 afterwards.
- Loop start=1, end=2, count=3, prog_end=3, program A..D → sequence A,B,C,B,C,B,C,D, then done_o.
- Same program, stall_i high for 3 cycles while PC=2 → C held for 4 cycles, pc_o=2 throughout; the total sequence is unchanged.
- stop_i asserted while PC=2 → next cycle IDLE, pc_o=0, done_o never pulses. A following start runs from A.
- Write to address 0 during RUN, then rerun → original word A still fetched. Simultaneous start_i+stop_i in IDLE → busy_o stays 0.
- Assert rst_i mid-loop (iter=1) → all outputs 0 immediately. A restart runs the full loop count.
